golden_stim_gen: RTL and testbench

Stimulus generator and expected-result model for the golden add/subtract datapath (`out = s ? a - c : a + b`, registered).
- Drives `a`, `b`, `c` and `s` from a seeded LFSR under a valid/ready handshake.
- Counts issued vectors and stops after a programmed number.
- For every accepted vector, emits the reference result after the datapath latency, so a downstream comparator can check `out` cycle by cycle.
- It is the transmit end of the golden top's operand interface.

---
 rtl/golden_stim_pkg.sv | 28 ++
 rtl/golden_lfsr16.sv | 22 ++
 rtl/golden_stim_gen.sv | 145 ++++++++++++++
 tb/tb_golden_stim_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/golden_stim_pkg.sv
// Shared types and helpers for the golden add/subtract stimulus generator.
package golden_stim_pkg;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'h0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stim_state_t;

  // Callers truncate the result to their datapath width; low bits of +/- only depend on low bits.
  function automatic logic [31:0] golden_ref(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic s);
    if (s) begin
      golden_ref = a - c;
    end else begin
      golden_ref = a + b;
    end
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] st);
    lfsr_step = (st >> 1) ^ (st[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/golden_lfsr16.sv
// 16-bit right-shift Galois LFSR with seed load; a zero seed is replaced by the default seed.
module golden_lfsr16 import golden_stim_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] state
);

  // Load takes priority over advance; the all-zero state would lock up the sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (adv) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/golden_stim_gen.sv
// Stimulus generator and expected-result model for the golden add/subtract datapath.
module golden_stim_gen import golden_stim_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic [7:0]       num_vec,
  input  logic             vec_ready,
  output logic             vec_valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             s,
  output logic             exp_valid,
  output logic [WIDTH-1:0] exp_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       sent_count
);

  stim_state_t      state_r;
  logic [7:0]       num_vec_r;
  logic [1:0]       drain_cnt_r;
  logic             zero_pend_r;
  logic             vec_valid_r;
  logic             busy_r;
  logic             done_r;
  logic [7:0]       sent_count_r;
  logic             pipe_valid_r [LATENCY];
  logic [WIDTH-1:0] pipe_data_r  [LATENCY];

  logic [15:0]      lfsr_state_s;
  logic             load_s;
  logic             hs_s;
  logic [WIDTH-1:0] ref_s;

  assign load_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign hs_s   = vec_valid_r && vec_ready;

  golden_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (load_s),
    .seed  (seed),
    .adv   (hs_s),
    .state (lfsr_state_s)
  );

  // Operands come straight off the LFSR register, gated quiet whenever no vector is offered.
  assign a = vec_valid_r ? WIDTH'(lfsr_state_s[7:0]) : {WIDTH{1'b0}};
  assign b = vec_valid_r ? WIDTH'(lfsr_state_s[15:8]) : {WIDTH{1'b0}};
  assign c = vec_valid_r ? WIDTH'(lfsr_state_s[7:0] ^ lfsr_state_s[15:8]) : {WIDTH{1'b0}};
  assign s = vec_valid_r & lfsr_state_s[0];

  assign ref_s = WIDTH'(golden_ref(32'(a), 32'(b), 32'(c), s));

  // Free-running expected-result delay line; it never stalls on vec_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_r[i] <= 1'b0;
        pipe_data_r[i]  <= {WIDTH{1'b0}};
      end
    end else begin
      pipe_valid_r[0] <= hs_s;
      pipe_data_r[0]  <= hs_s ? ref_s : {WIDTH{1'b0}};
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_data_r[i]  <= pipe_data_r[i-1];
      end
    end
  end

  // Run control: start sampling, vector counting, drain timing and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      num_vec_r    <= 8'd0;
      drain_cnt_r  <= 2'd0;
      zero_pend_r  <= 1'b0;
      vec_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      sent_count_r <= 8'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          // An empty run parks in DONE for one cycle before pulsing done.
          if (zero_pend_r) begin
            done_r      <= 1'b1;
            zero_pend_r <= 1'b0;
          end
          if (start) begin
            num_vec_r    <= num_vec;
            sent_count_r <= 8'd0;
            if (num_vec != 8'd0) begin
              state_r     <= RUN;
              vec_valid_r <= 1'b1;
              busy_r      <= 1'b1;
            end else begin
              state_r     <= DONE;
              zero_pend_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs_s) begin
            sent_count_r <= sent_count_r + 8'd1;
            if ((sent_count_r + 8'd1) == num_vec_r) begin
              state_r     <= DRAIN;
              vec_valid_r <= 1'b0;
              drain_cnt_r <= 2'd0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_r == 2'(LATENCY - 1)) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
          end
        end
        default: begin
          state_r     <= IDLE;
          vec_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign vec_valid  = vec_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign sent_count = sent_count_r;
  assign exp_valid  = pipe_valid_r[LATENCY-1];
  assign exp_out    = pipe_data_r[LATENCY-1];

endmodule

// File: tb/tb_golden_stim_gen.sv
// Directed bench for golden_stim_gen with a two-cycle expected-result latency.
module tb_golden_stim_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] seed;
  logic [7:0]  num_vec;
  logic        vec_ready;
  logic        vec_valid;
  logic [7:0]  a, b, c;
  logic        s;
  logic        exp_valid;
  logic [7:0]  exp_out;
  logic        busy;
  logic        done;
  logic [7:0]  sent_count;

  int checks   = 0;
  int failures = 0;

  golden_stim_gen #(.WIDTH(8), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .num_vec    (num_vec),
    .vec_ready  (vec_ready),
    .vec_valid  (vec_valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .s          (s),
    .exp_valid  (exp_valid),
    .exp_out    (exp_out),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector packed as {a, b, c, 7'b0, s}.
  function automatic logic [31:0] vec_word();
    return {a, b, c, 7'b0000000, s};
  endfunction

  function automatic logic [31:0] exp_word();
    return 32'({exp_valid, exp_out});
  endfunction

  task automatic wait_done(input string tag);
    int  n   = 0;
    logic got = 1'b0;
    while (!got && n < 12) begin
      tick();
      if (done) got = 1'b1;
      n++;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  logic saw_done;
  logic saw_exp;

  initial begin
    reset = 1'b1; start = 1'b0; seed = 16'h0000; num_vec = 8'd0; vec_ready = 1'b0;
    tick(); tick();
    chk("rst_vec_valid", 32'(vec_valid), 32'd0);
    chk("rst_exp", exp_word(), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vec", vec_word(), 32'd0);
    chk("rst_sent", 32'(sent_count), 32'd0);
    reset = 1'b0;
    tick();

    // Basic three-vector run
    seed = 16'h0001; num_vec = 8'd3; vec_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("basic_v1", vec_word(), 32'h0100_0101);
    chk("basic_busy", 32'(busy), 32'd1);
    tick();
    chk("basic_v2", vec_word(), 32'h00B4_B400);
    chk("basic_cnt1", 32'(sent_count), 32'd1);
    chk("basic_no_exp_yet", exp_word(), 32'd0);
    tick();
    chk("basic_v3", vec_word(), 32'h005A_5A00);
    chk("basic_exp1", exp_word(), 32'h100);
    tick();
    chk("basic_drain_valid", 32'(vec_valid), 32'd0);
    chk("basic_cnt3", 32'(sent_count), 32'd3);
    chk("basic_exp2", exp_word(), 32'h1B4);
    tick();
    chk("basic_exp3", exp_word(), 32'h15A);
    chk("basic_done_early", 32'(done), 32'd0);
    chk("basic_busy_drain", 32'(busy), 32'd1);
    tick();
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy_fall", 32'(busy), 32'd0);
    chk("basic_exp_end", 32'(exp_valid), 32'd0);
    tick();
    chk("basic_done_pulse", 32'(done), 32'd0);
    chk("basic_cnt_hold", 32'(sent_count), 32'd3);

    // Add with carry out
    seed = 16'hFF80; num_vec = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("add_vec", vec_word(), 32'h80FF_7F00);
    tick();
    chk("add_cnt", 32'(sent_count), 32'd1);
    tick();
    chk("add_exp", exp_word(), 32'h17F);
    wait_done("add_done");

    // Subtract with borrow
    seed = 16'h8001; num_vec = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("sub_vec", vec_word(), 32'h0180_8101);
    tick(); tick();
    chk("sub_exp", exp_word(), 32'h180);
    wait_done("sub_done");

    // Backpressure: three stalled cycles on the first vector
    seed = 16'h0001; num_vec = 8'd3; vec_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("bp_v1", vec_word(), 32'h0100_0101);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", vec_word(), 32'h0100_0101);
      chk("bp_cnt", 32'(sent_count), 32'd0);
      chk("bp_no_exp", 32'(exp_valid), 32'd0);
    end
    vec_ready = 1'b1;
    tick();
    chk("bp_v2", vec_word(), 32'h00B4_B400);
    chk("bp_exp_wait", 32'(exp_valid), 32'd0);
    tick();
    chk("bp_v3", vec_word(), 32'h005A_5A00);
    chk("bp_exp1", exp_word(), 32'h100);
    wait_done("bp_done");

    // Zero-length run
    seed = 16'h1234; num_vec = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("zero_valid", 32'(vec_valid), 32'd0);
    chk("zero_done_early", 32'(done), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_valid2", 32'(vec_valid), 32'd0);
    tick();
    chk("zero_done_pulse", 32'(done), 32'd0);

    // start held through RUN with different seed/num_vec is ignored
    seed = 16'h0001; num_vec = 8'd3; vec_ready = 1'b1; start = 1'b1;
    tick();
    chk("ign_v1", vec_word(), 32'h0100_0101);
    seed = 16'hFF80; num_vec = 8'd1;
    tick();
    chk("ign_v2", vec_word(), 32'h00B4_B400);
    tick(); start = 1'b0;
    chk("ign_v3", vec_word(), 32'h005A_5A00);
    chk("ign_cnt2", 32'(sent_count), 32'd2);
    tick();
    chk("ign_cnt3", 32'(sent_count), 32'd3);
    chk("ign_drain", 32'(vec_valid), 32'd0);
    wait_done("ign_done");

    // Zero seed behaves as seed 1
    seed = 16'h0000; num_vec = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("seed0_vec", vec_word(), 32'h0100_0101);
    tick(); tick();
    chk("seed0_exp", exp_word(), 32'h100);
    wait_done("seed0_done");

    // Reset after two of five handshakes
    seed = 16'h0001; num_vec = 8'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("mr_cnt2", 32'(sent_count), 32'd2);
    reset = 1'b1;
    #1;
    chk("mr_valid", 32'(vec_valid), 32'd0);
    chk("mr_vec", vec_word(), 32'd0);
    chk("mr_exp", exp_word(), 32'd0);
    chk("mr_cnt", 32'(sent_count), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    saw_done = 1'b0; saw_exp = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) saw_done = 1'b1;
      if (exp_valid) saw_exp = 1'b1;
    end
    chk("mr_no_done", 32'(saw_done), 32'd0);
    chk("mr_no_exp", 32'(saw_exp), 32'd0);
    seed = 16'hFF80; num_vec = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("mr_restart_vec", vec_word(), 32'h80FF_7F00);
    tick(); tick();
    chk("mr_restart_exp", exp_word(), 32'h17F);
    wait_done("mr_restart_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
